// File: rtl/colour_grid_pkg.sv
// Shared types and helpers for the touch-interactive colour grid.
package colour_grid_pkg;

    localparam int MAX_REGIONS = 256;
    localparam int REGION_W    = $clog2(MAX_REGIONS);

    typedef logic [2:0] palette_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } press_state_t;

    // Palette index bits are {R,G,B}; each set bit drives a full-scale channel.
    function automatic logic [23:0] idx_to_rgb(input palette_t idx);
        return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    endfunction

endpackage

// File: rtl/colour_grid_generator_locator.sv
// Maps a 10-bit coordinate onto one of N equal spans, clamping to the last span.
module grid_region_locator #(
    parameter int N    = 4,
    parameter int SPAN = 200
) (
    input  logic [9:0] coord,
    output logic [3:0] index
);

    // Counting the boundaries at or below coord gives the span index; stopping
    // at N-1 boundaries clamps anything past the active area to the last span.
    always_comb begin
        index = '0;
        for (int c = 0; c < N - 1; c++) begin
            if ((c + 1) * SPAN <= int'(coord)) begin
                index = index + 4'd1;
            end
        end
    end

endmodule

// File: rtl/colour_grid_generator.sv
// Touch-interactive colour grid: per-region palette store, press FSM and
// a one-cycle registered pixel colour path.
module colour_grid_generator
    import colour_grid_pkg::*;
#(
    parameter int N_COLS   = 4,
    parameter int N_ROWS   = 2,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int TP_BITS  = 12
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [9:0]          Coord_X,
    input  logic [9:0]          Coord_Y,
    input  logic                Touch_En,
    input  logic                Coord_En,
    input  logic [TP_BITS-1:0]  TP_X,
    input  logic [TP_BITS-1:0]  TP_Y,
    input  logic                Clear,
    input  logic                Highlight_En,
    output logic [7:0]          Red,
    output logic [7:0]          Green,
    output logic [7:0]          Blue,
    output logic [REGION_W-1:0] Sel_Region,
    output logic                Sel_Valid
);

    localparam int N_REGIONS = N_COLS * N_ROWS;
    localparam int COL_W     = H_ACTIVE / N_COLS;
    localparam int ROW_H     = V_ACTIVE / N_ROWS;
    localparam int PROD_W    = TP_BITS + 10;

    function automatic logic [REGION_W-1:0] region_of(input logic [3:0] row,
                                                      input logic [3:0] col);
        return REGION_W'(row) * REGION_W'(N_COLS) + REGION_W'(col);
    endfunction

    logic [3:0]          px_col, px_row, tp_col, tp_row;
    logic [REGION_W-1:0] px_region, tp_region;
    logic [PROD_W-1:0]   tx_prod, ty_prod;
    logic [9:0]          tx_d, ty_d;

    palette_t            colour_idx [N_REGIONS];
    palette_t            px_idx;
    logic [23:0]         px_rgb;
    logic [23:0]         rgb_p1;

    press_state_t        state_q, state_d;
    logic                press_fire;

    grid_region_locator #(.N(N_COLS), .SPAN(COL_W)) u_px_col (.coord(Coord_X), .index(px_col));
    grid_region_locator #(.N(N_ROWS), .SPAN(ROW_H)) u_px_row (.coord(Coord_Y), .index(px_row));

    // Raw panel coordinates scale into display pixels with a fixed-width product.
    assign tx_prod = PROD_W'(TP_X) * PROD_W'(H_ACTIVE);
    assign ty_prod = PROD_W'(TP_Y) * PROD_W'(V_ACTIVE);
    assign tx_d    = 10'(tx_prod >> TP_BITS);
    assign ty_d    = 10'(ty_prod >> TP_BITS);

    grid_region_locator #(.N(N_COLS), .SPAN(COL_W)) u_tp_col (.coord(tx_d), .index(tp_col));
    grid_region_locator #(.N(N_ROWS), .SPAN(ROW_H)) u_tp_row (.coord(ty_d), .index(tp_row));

    assign px_region = region_of(px_row, px_col);
    assign tp_region = region_of(tp_row, tp_col);

    // Press FSM: one increment per pen-down, and a pen held through reset must lift first.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        press_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!Touch_En) state_d = ARMED;
            end
            ARMED: begin
                if (Coord_En && Touch_En) begin
                    press_fire = 1'b1;
                    state_d    = HELD;
                end
            end
            HELD: begin
                if (!Touch_En) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Colour store and selection; Clear overrides a coincident press.
    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            for (int r = 0; r < N_REGIONS; r++) begin
                colour_idx[r] <= palette_t'(r);
            end
            Sel_Valid <= 1'b0;
            if (Reset) Sel_Region <= '0;
        end else if (press_fire) begin
            for (int r = 0; r < N_REGIONS; r++) begin
                if (REGION_W'(r) == tp_region) begin
                    colour_idx[r] <= colour_idx[r] + 3'd1;
                end
            end
            Sel_Region <= tp_region;
            Sel_Valid  <= 1'b1;
        end
    end

    always_comb begin
        px_idx = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            if (REGION_W'(r) == px_region) px_idx = colour_idx[r];
        end
        px_rgb = idx_to_rgb(px_idx);
    end

    // ---- stage p1: registered pixel colour ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rgb_p1 <= '0;
        end else if (Highlight_En && Sel_Valid && (px_region == Sel_Region)) begin
            rgb_p1 <= ~px_rgb;
        end else begin
            rgb_p1 <= px_rgb;
        end
    end

    assign Red   = rgb_p1[23:16];
    assign Green = rgb_p1[15:8];
    assign Blue  = rgb_p1[7:0];

endmodule
